// File: rtl/lc3_int_ctrl.sv
// rtl/lc3_int_ctrl.sv - LC-3 interrupt controller: edge-latched requests, mask, priority arbitration.
// Presents one interrupt at a time to the control FSM and holds its vector until acknowledged or withdrawn.
module lc3_int_ctrl #(
  parameter logic [2:0] PRIO0 = 3'd4,
  parameter logic [2:0] PRIO1 = 3'd4,
  parameter logic [2:0] PRIO2 = 3'd6,
  parameter logic [2:0] PRIO3 = 3'd2,
  parameter logic [7:0] VEC0  = 8'h80,
  parameter logic [7:0] VEC1  = 8'h81,
  parameter logic [7:0] VEC2  = 8'h82,
  parameter logic [7:0] VEC3  = 8'h83
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] main_bus,
  input  logic [3:0]  irq,
  input  logic [2:0]  PSR_PL,
  input  logic        LD_INTMASK,
  input  logic        GateINTMASK,
  input  logic        INT_ack,
  output logic        INT,
  output logic [7:0]  INTV
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam logic [11:0] PRIO_PK = {PRIO3, PRIO2, PRIO1, PRIO0};
  localparam logic [31:0] VEC_PK  = {VEC3, VEC2, VEC1, VEC0};

  state_t     state;
  logic [3:0] irq_q;
  logic [3:0] pending;
  logic [3:0] pending_next;
  logic [3:0] mask;
  logic [1:0] sel;
  logic [3:0] eligible;
  logic [1:0] best;
  logic [2:0] best_prio;
  logic       any_eligible;
  logic [11:0] unused_bus_bits;

  assign unused_bus_bits = main_bus[15:4];

  // The status is driven only while gated so the bus stays shareable.
  assign main_bus = GateINTMASK ? {8'h00, pending, mask} : 16'hzzzz;

  always_comb begin
    eligible = 4'h0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = pending[i] & mask[i] & (PRIO_PK[3*i +: 3] > PSR_PL);
    end
  end

  // Ascending scan with strict '>' leaves ties with the lowest index.
  always_comb begin
    any_eligible = 1'b0;
    best         = 2'd0;
    best_prio    = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i] && (!any_eligible || PRIO_PK[3*i +: 3] > best_prio)) begin
        any_eligible = 1'b1;
        best         = 2'(i);
        best_prio    = PRIO_PK[3*i +: 3];
      end
    end
  end

  // A fresh rising edge is OR-ed in last so it wins over an ack clear.
  always_comb begin
    pending_next = pending;
    if (state == S_REQ && INT_ack) begin
      pending_next[sel] = 1'b0;
    end
    pending_next = pending_next | (irq & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      INT     <= 1'b0;
      INTV    <= 8'h00;
      sel     <= 2'd0;
      mask    <= 4'h0;
      pending <= 4'h0;
      irq_q   <= 4'h0;
    end else begin
      irq_q   <= irq;
      pending <= pending_next;
      if (LD_INTMASK) begin
        mask <= main_bus[3:0];
      end
      case (state)
        S_IDLE: begin
          if (any_eligible) begin
            sel   <= best;
            INTV  <= VEC_PK[{best, 3'b000} +: 8];
            INT   <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (INT_ack) begin
            INT   <= 1'b0;
            state <= S_HOLD;
          end else if (!eligible[sel]) begin
            INT   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          INT   <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          INT   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// tb/tb_lc3_int_ctrl.sv - table-driven bench for lc3_int_ctrl plus directed corner sequences.
module tb_lc3_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] main_bus;
  logic [3:0]  irq;
  logic [2:0]  PSR_PL;
  logic        LD_INTMASK;
  logic        GateINTMASK;
  logic        INT_ack;
  logic        INT;
  logic [7:0]  INTV;
  logic [15:0] bus_drv;
  logic        bus_en;

  int checks = 0;
  int errors = 0;

  assign main_bus = bus_en ? bus_drv : 16'hzzzz;

  lc3_int_ctrl dut (
    .clk(clk), .rst(rst), .main_bus(main_bus), .irq(irq), .PSR_PL(PSR_PL),
    .LD_INTMASK(LD_INTMASK), .GateINTMASK(GateINTMASK), .INT_ack(INT_ack),
    .INT(INT), .INTV(INTV)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic [2:0]  pl;
    logic        ld;
    logic [15:0] wdata;
    logic        gate;
    logic        ack;
    logic        exp_int;
    logic [7:0]  exp_intv;
    logic        chk_bus;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t tv [13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] i_irq, input logic [2:0] pl, input logic ld,
                       input logic [15:0] wd, input logic gt, input logic ak);
    irq         = i_irq;
    PSR_PL      = pl;
    LD_INTMASK  = ld;
    bus_en      = ld;
    bus_drv     = wd;
    GateINTMASK = gt;
    INT_ack     = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        irq   pl    ld    wdata     gate  ack   int   intv   chkb  bus
    tv[0]  = '{4'h0, 3'd3, 1'b1, 16'hFFF1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
    tv[1]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
    tv[2]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 16'h0000};
    tv[3]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 16'h0011};
    tv[4]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 16'h0001};
    tv[5]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 16'h0000};
    tv[6]  = '{4'h1, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 16'h0001};
    tv[7]  = '{4'h1, 3'd4, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 16'h0000};
    tv[8]  = '{4'h3, 3'd4, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 16'h0000};
    tv[9]  = '{4'h3, 3'd4, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 16'h0022};
    tv[10] = '{4'h3, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 16'h0000};
    tv[11] = '{4'h3, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 16'h0002};
    tv[12] = '{4'h0, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 16'h0000};

    rst = 1'b1;
    drive(4'h0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    tick();
    check("rst.int", {15'd0, INT}, 16'h0000);
    check("rst.intv", {8'd0, INTV}, 16'h0000);
    check("rst.bus", main_bus, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].irq, tv[i].pl, tv[i].ld, tv[i].wdata, tv[i].gate, tv[i].ack);
      tick();
      check($sformatf("v%0d.int", i), {15'd0, INT}, {15'd0, tv[i].exp_int});
      check($sformatf("v%0d.intv", i), {8'd0, INTV}, {8'd0, tv[i].exp_intv});
      if (tv[i].chk_bus) check($sformatf("v%0d.bus", i), main_bus, tv[i].exp_bus);
    end

    // Two sources at once: higher priority first, the other after HOLD.
    drive(4'h0, 3'd0, 1'b1, 16'h000F, 1'b0, 1'b0); tick();
    drive(4'h5, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    check("prio.pre", {15'd0, INT}, 16'h0000);
    tick();
    check("prio.int", {15'd0, INT}, 16'h0001);
    check("prio.intv", {8'd0, INTV}, 16'h0082);
    INT_ack = 1'b1; tick();
    check("ack.int", {15'd0, INT}, 16'h0000);
    INT_ack = 1'b0; tick();
    check("hold.int", {15'd0, INT}, 16'h0000);
    tick();
    check("rearb.int", {15'd0, INT}, 16'h0001);
    check("rearb.intv", {8'd0, INTV}, 16'h0080);

    // Withdrawal by raising PSR_PL keeps the request pending.
    PSR_PL = 3'd7; GateINTMASK = 1'b1; tick();
    check("wd.int", {15'd0, INT}, 16'h0000);
    check("wd.bus", main_bus, 16'h001F);
    PSR_PL = 3'd0; GateINTMASK = 1'b0; tick();
    check("wd.reint", {15'd0, INT}, 16'h0001);
    check("wd.intv", {8'd0, INTV}, 16'h0080);

    // Reset mid-REQ with ack, then a line held high through reset.
    rst = 1'b1; INT_ack = 1'b1; GateINTMASK = 1'b1; tick();
    check("rreq.int", {15'd0, INT}, 16'h0000);
    check("rreq.intv", {8'd0, INTV}, 16'h0000);
    check("rreq.bus", main_bus, 16'h0000);
    rst = 1'b0; INT_ack = 1'b0; tick();
    check("post_rst.bus", main_bus, 16'h0050);
    tick();
    check("post_rst.int", {15'd0, INT}, 16'h0000);

    // Upper bus bits are ignored on mask load.
    irq = 4'h0; rst = 1'b1; tick();
    rst = 1'b0;
    drive(4'h0, 3'd0, 1'b1, 16'hFFF5, 1'b0, 1'b0); tick();
    drive(4'h0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
    check("mask.bus", main_bus, 16'h0005);
    check("mask.int", {15'd0, INT}, 16'h0000);

    // Equal priority sources: lowest index wins.
    drive(4'h0, 3'd0, 1'b1, 16'h000F, 1'b0, 1'b0); tick();
    drive(4'h3, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0); tick();
    tick();
    check("tie.int", {15'd0, INT}, 16'h0001);
    check("tie.intv", {8'd0, INTV}, 16'h0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
